div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider with start/annul handshake for an execute stage.
// Optional signed operation is built only when macro DIV_SIGNED_EN is defined.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  localparam logic [5:0] LAST_CNT = 6'(DATA_W);

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   dividend_abs;
  logic [DATA_W-1:0]   divisor_abs;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic                neg_q_in;
  logic                neg_r_in;
  logic                neg_q;
  logic                neg_r;

  assign diff       = work[2*DATA_W:DATA_W] - {1'b0, divisor};
  assign stallreq_o = start_i & ~ready_o;

`ifdef DIV_SIGNED_EN
  always_comb begin
    neg_q_in     = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
    neg_r_in     = signed_div_i & opdata1_i[DATA_W-1];
    dividend_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quot         = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
    rem          = neg_r ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];
  end
`else
  // Unsigned-only build: the mode input is intentionally left without a load.
  logic unused_signed_div;
  assign unused_signed_div = signed_div_i;

  always_comb begin
    neg_q_in     = 1'b0;
    neg_r_in     = 1'b0;
    dividend_abs = opdata1_i;
    divisor_abs  = opdata2_i;
    quot         = work[DATA_W-1:0];
    rem          = work[2*DATA_W:DATA_W+1];
  end
`endif

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // the working registers are plain flops, so they are cleared by reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i && state != S_FREE) begin
      // A flushed divide never reports a result.
      state    <= S_FREE;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            work    <= {{DATA_W{1'b0}}, dividend_abs, 1'b0};
            divisor <= divisor_abs;
            neg_q   <= neg_q_in;
            neg_r   <= neg_r_in;
            cnt     <= '0;
            state   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= S_END;
        end
        S_ON: begin
          if (cnt != LAST_CNT) begin
            // Restoring step: subtract when it fits and shift a 1 into the quotient.
            work <= diff[DATA_W] ? {work[2*DATA_W-1:0], 1'b0}
                                 : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt  <= cnt + 6'd1;
          end else begin
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
            state    <= S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= S_FREE;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule
